// File: rtl/local_mem_avmm_bridge.sv
// Avalon-MM pipeline bridge between the memory-test FSM master (s_*) and the
// EMIF/local-memory slave (m_*). Commands pass through a 2-entry skid buffer
// whose head register drives the m_* bus directly. Read issue is gated by a
// beat-credit counter. Read data returns through one register stage. A sticky
// flag records protocol violations.
module local_mem_avmm_bridge #(
    parameter int DATA_WIDTH        = 512,
    parameter int ADDR_WIDTH        = 26,
    parameter int BURST_WIDTH       = 7,
    parameter int MAX_PENDING_READS = 64
) (
    input  logic                                 clk,
    input  logic                                 SoftReset_n,
    input  logic [ADDR_WIDTH-1:0]                s_address,
    input  logic [DATA_WIDTH-1:0]                s_writedata,
    input  logic [DATA_WIDTH/8-1:0]              s_byteenable,
    input  logic [BURST_WIDTH-1:0]               s_burstcount,
    input  logic                                 s_read,
    input  logic                                 s_write,
    output logic                                 s_waitrequest,
    output logic [DATA_WIDTH-1:0]                s_readdata,
    output logic                                 s_readdatavalid,
    output logic [ADDR_WIDTH-1:0]                m_address,
    output logic [DATA_WIDTH-1:0]                m_writedata,
    output logic [DATA_WIDTH/8-1:0]              m_byteenable,
    output logic [BURST_WIDTH-1:0]               m_burstcount,
    output logic                                 m_read,
    output logic                                 m_write,
    input  logic                                 m_waitrequest,
    input  logic [DATA_WIDTH-1:0]                m_readdata,
    input  logic                                 m_readdatavalid,
    output logic [$clog2(MAX_PENDING_READS):0]   pending_beats,
    output logic                                 proto_err
);

    localparam int          BE_WIDTH   = DATA_WIDTH / 8;
    localparam int          PEND_WIDTH = $clog2(MAX_PENDING_READS) + 1;
    localparam logic [31:0] MAX_PEND   = MAX_PENDING_READS;

    // One buffered command: a single Avalon beat with its burst length.
    typedef struct packed {
        logic                   is_write;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [DATA_WIDTH-1:0]  data;
        logic [BE_WIDTH-1:0]    be;
        logic [BURST_WIDTH-1:0] burst;
    } cmd_t;

    cmd_t                  head_q, head_d, tail_q, tail_d, new_cmd;
    logic                  head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
    logic                  swait_q, swait_d;
    logic [PEND_WIDTH-1:0] pend_q, pend_d;
    logic                  err_q, err_d;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic push, pop, credit_ok, issue_rd, issue_wr, rd_issued, rd_ret, stray;

    // Next-state for the skid buffer, stall flag, read credits and error flag.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        head_d     = head_q;
        tail_d     = tail_q;
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;

        push = (s_read | s_write) & ~swait_q;

        // A simultaneous read+write is taken as a write; burst 0 becomes 1.
        new_cmd.is_write = s_write;
        new_cmd.addr     = s_address;
        new_cmd.data     = s_writedata;
        new_cmd.be       = s_byteenable;
        new_cmd.burst    = (s_burstcount == '0) ? BURST_WIDTH'(1) : s_burstcount;

        // A read head is shown only when its whole burst fits in the credit window.
        credit_ok = (32'(pend_q) + 32'(head_q.burst)) <= MAX_PEND;
        issue_rd  = head_vld_q & ~head_q.is_write & credit_ok;
        issue_wr  = head_vld_q & head_q.is_write;
        pop       = (issue_rd | issue_wr) & ~m_waitrequest;
        rd_issued = issue_rd & ~m_waitrequest;

        if (pop) begin
            head_d     = tail_q;
            head_vld_d = tail_vld_q;
            tail_vld_d = 1'b0;
        end
        if (push) begin
            if (!head_vld_d) begin
                head_d     = new_cmd;
                head_vld_d = 1'b1;
            end else begin
                tail_d     = new_cmd;
                tail_vld_d = 1'b1;
            end
        end
        swait_d = head_vld_d & tail_vld_d;

        // A beat returning with no credit outstanding is flagged and not counted.
        rd_ret = m_readdatavalid & (pend_q != '0);
        stray  = m_readdatavalid & (pend_q == '0);
        pend_d = pend_q + (rd_issued ? PEND_WIDTH'(head_q.burst) : '0) - PEND_WIDTH'(rd_ret);

        err_d = err_q | stray | (push & s_read & s_write) | (push & (s_burstcount == '0));
    end

    // Register all bridge state; reset empties the buffer and drops all credits.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            // NOTE: the payload registers are reset as well, so nothing stale is
            // left on the m_* bus after a reset mid-burst.
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            swait_q    <= 1'b1;
            pend_q     <= '0;
            err_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            swait_q    <= swait_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            rvalid_q   <= m_readdatavalid;
            rdata_q    <= m_readdata;
        end
    end

    assign s_waitrequest   = swait_q;
    assign s_readdata      = rdata_q;
    assign s_readdatavalid = rvalid_q;
    assign m_address       = head_q.addr;
    assign m_writedata     = head_q.data;
    assign m_byteenable    = head_q.be;
    assign m_burstcount    = head_q.burst;
    assign m_read          = issue_rd;
    assign m_write         = issue_wr;
    assign pending_beats   = pend_q;
    assign proto_err       = err_q;

endmodule

// File: tb/tb_local_mem_avmm_bridge.sv
// Self-checking bench for local_mem_avmm_bridge: directed scenarios followed
// by a randomized phase, all checked against a queue-based command model.
module tb_local_mem_avmm_bridge;

    localparam int DW   = 512;
    localparam int AW   = 26;
    localparam int BW   = 7;
    localparam int MAXP = 64;
    localparam int PW   = $clog2(MAXP) + 1;

    logic            clk = 1'b0;
    logic            SoftReset_n;
    logic [AW-1:0]   s_address;
    logic [DW-1:0]   s_writedata;
    logic [DW/8-1:0] s_byteenable;
    logic [BW-1:0]   s_burstcount;
    logic            s_read, s_write, s_waitrequest;
    logic [DW-1:0]   s_readdata;
    logic            s_readdatavalid;
    logic [AW-1:0]   m_address;
    logic [DW-1:0]   m_writedata;
    logic [DW/8-1:0] m_byteenable;
    logic [BW-1:0]   m_burstcount;
    logic            m_read, m_write, m_waitrequest;
    logic [DW-1:0]   m_readdata;
    logic            m_readdatavalid;
    logic [PW-1:0]   pending_beats;
    logic            proto_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: buffered commands in order, outstanding beats, error flag.
    typedef struct {
        bit              wr;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic [DW/8-1:0] be;
        int              burst;
    } cmd_t;

    cmd_t          exp_q[$];
    int            pend_m;
    bit            err_m;
    bit            after_rst;
    bit            rv_m;
    logic [DW-1:0] rd_m;
    int            wr_xfers = 0;

    local_mem_avmm_bridge #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW), .MAX_PENDING_READS(MAXP)
    ) dut (
        .clk(clk), .SoftReset_n(SoftReset_n),
        .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_burstcount(s_burstcount), .s_read(s_read), .s_write(s_write),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_burstcount(m_burstcount), .m_read(m_read), .m_write(m_write),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .pending_beats(pending_beats), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic bit exp_swait();
        return after_rst || (exp_q.size() == 2);
    endfunction

    task automatic set_idle();
        s_read          = 1'b0;
        s_write         = 1'b0;
        s_address       = '0;
        s_writedata     = '0;
        s_byteenable    = '0;
        s_burstcount    = '0;
        m_waitrequest   = 1'b0;
        m_readdatavalid = 1'b0;
        m_readdata      = '0;
    endtask

    task automatic drive_cmd(input bit rd, input bit wr, input int addr, input int burst);
        s_read       = rd;
        s_write      = wr;
        s_address    = AW'(addr);
        s_writedata  = rand_data();
        s_byteenable = {$urandom, $urandom};
        s_burstcount = BW'(burst);
    endtask

    // Check the current cycle against the model, advance the model over the
    // coming edge using the inputs now applied, then step to 1 after that edge.
    task automatic tick();
        bit   mw_e, mr_e, sw_e;
        cmd_t h;
        int   old;
        sw_e = exp_swait();
        mw_e = 1'b0;
        mr_e = 1'b0;
        if (exp_q.size() > 0) begin
            h    = exp_q[0];
            mw_e = h.wr;
            mr_e = !h.wr && (pend_m + h.burst <= MAXP);
        end
        check("s_waitrequest", s_waitrequest, sw_e);
        check("m_write", m_write, mw_e);
        check("m_read", m_read, mr_e);
        if (mw_e || mr_e) begin
            check("m_address", m_address, h.addr);
            check("m_burstcount", m_burstcount, h.burst);
            if (mw_e) begin
                check("m_writedata", m_writedata, h.data);
                check("m_byteenable", m_byteenable, h.be);
            end
        end
        check("pending_beats", pending_beats, pend_m);
        check("proto_err", proto_err, err_m);
        check("s_readdatavalid", s_readdatavalid, rv_m);
        if (rv_m) check("s_readdata", s_readdata, rd_m);

        old = pend_m;
        if (mr_e && !m_waitrequest) pend_m += h.burst;
        if (m_readdatavalid) begin
            if (old > 0) pend_m--;
            else err_m = 1'b1;
        end
        if ((mw_e || mr_e) && !m_waitrequest) void'(exp_q.pop_front());
        if ((s_read || s_write) && !sw_e) begin
            cmd_t c;
            c.wr    = s_write;
            c.addr  = s_address;
            c.data  = s_writedata;
            c.be    = s_byteenable;
            c.burst = (s_burstcount == 0) ? 1 : int'(s_burstcount);
            if ((s_read && s_write) || s_burstcount == 0) err_m = 1'b1;
            exp_q.push_back(c);
        end
        rv_m = m_readdatavalid;
        rd_m = m_readdata;
        if (m_write && !m_waitrequest) wr_xfers++;
        after_rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Run until the model is empty, returning read beats as credit allows.
    task automatic drain();
        int n = 0;
        s_read        = 1'b0;
        s_write       = 1'b0;
        m_waitrequest = 1'b0;
        while ((exp_q.size() > 0 || pend_m > 0) && n < 500) begin
            m_readdatavalid = (pend_m > 0);
            m_readdata      = rand_data();
            tick();
            n++;
        end
        m_readdatavalid = 1'b0;
        check("drain_done", n < 500, 1'b1);
    endtask

    // Assert reset mid-cycle, check outputs right away, release between edges.
    task automatic do_reset();
        SoftReset_n = 1'b0;
        set_idle();
        #1;
        check("rst_m_read", m_read, 1'b0);
        check("rst_m_write", m_write, 1'b0);
        check("rst_pending", pending_beats, 0);
        check("rst_swait", s_waitrequest, 1'b1);
        check("rst_proto_err", proto_err, 1'b0);
        check("rst_rvalid", s_readdatavalid, 1'b0);
        check("rst_m_address", m_address, 0);
        exp_q.delete();
        pend_m    = 0;
        err_m     = 1'b0;
        rv_m      = 1'b0;
        after_rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        SoftReset_n = 1'b1;
    endtask

    initial begin
        int            base;
        int            n;
        logic [DW-1:0] stray_data;
        SoftReset_n = 1'b0;
        set_idle();
        @(posedge clk);
        #1;
        do_reset();
        tick();
        check("swait_after_release", s_waitrequest, 1'b0);

        // Single write
        drive_cmd(1'b0, 1'b1, 'h10, 1);
        s_writedata  = {64{8'hA5}};
        s_byteenable = '1;
        tick();
        set_idle();
        check("single_m_write", m_write, 1'b1);
        check("single_addr", m_address, 'h10);
        check("single_data", m_writedata, {64{8'hA5}});
        check("single_be", m_byteenable, {64{1'b1}});
        check("single_swait", s_waitrequest, 1'b0);
        tick();
        check("single_write_one_cycle", m_write, 1'b0);

        // Backpressure: three writes while the slave stalls for five cycles
        base          = wr_xfers;
        m_waitrequest = 1'b1;
        drive_cmd(1'b0, 1'b1, 'h100, 1);
        tick();
        drive_cmd(1'b0, 1'b1, 'h101, 1);
        tick();
        check("bp_swait_after_2nd", s_waitrequest, 1'b1);
        drive_cmd(1'b0, 1'b1, 'h102, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_stable_addr", m_address, 'h100);
            check("bp_stable_write", m_write, 1'b1);
        end
        m_waitrequest = 1'b0;
        n = 0;
        while (exp_swait() && n < 10) begin
            tick();
            n++;
        end
        tick();
        set_idle();
        drain();
        check("bp_write_count", wr_xfers - base, 3);

        // Read burst of 4 with returned data 1..4
        drive_cmd(1'b1, 1'b0, 'h40, 4);
        tick();
        set_idle();
        check("rd_m_read", m_read, 1'b1);
        tick();
        check("rd_pending_4", pending_beats, 4);
        for (int k = 1; k <= 4; k++) begin
            m_readdatavalid = 1'b1;
            m_readdata      = DW'(k);
            tick();
            check("rd_pending", pending_beats, 4 - k);
            check("rd_resp_valid", s_readdatavalid, 1'b1);
            check("rd_resp_data", s_readdata, k);
        end
        m_readdatavalid = 1'b0;
        tick();
        check("rd_resp_idle", s_readdatavalid, 1'b0);

        // Credit limit: burst 64 then burst 1
        drive_cmd(1'b1, 1'b0, 'h200, 64);
        tick();
        drive_cmd(1'b1, 1'b0, 'h240, 1);
        tick();
        set_idle();
        check("cr_pending_64", pending_beats, 64);
        check("cr_withheld", m_read, 1'b0);
        tick();
        check("cr_withheld_2", m_read, 1'b0);
        m_readdatavalid = 1'b1;
        m_readdata      = rand_data();
        tick();
        m_readdatavalid = 1'b0;
        check("cr_pending_63", pending_beats, 63);
        check("cr_issue", m_read, 1'b1);
        check("cr_issue_addr", m_address, 'h240);
        drain();

        // Stray read beat with nothing outstanding
        stray_data      = rand_data();
        m_readdatavalid = 1'b1;
        m_readdata      = stray_data;
        tick();
        m_readdatavalid = 1'b0;
        check("stray_pending_0", pending_beats, 0);
        check("stray_proto_err", proto_err, 1'b1);
        check("stray_fwd_valid", s_readdatavalid, 1'b1);
        check("stray_fwd_data", s_readdata, stray_data);

        // Reset with two entries buffered and 8 beats pending
        drive_cmd(1'b1, 1'b0, 'h300, 8);
        tick();
        set_idle();
        tick();
        check("mid_pending_8", pending_beats, 8);
        m_waitrequest = 1'b1;
        drive_cmd(1'b0, 1'b1, 'h310, 1);
        tick();
        drive_cmd(1'b0, 1'b1, 'h311, 1);
        tick();
        check("mid_two_buffered", s_waitrequest, 1'b1);
        do_reset();
        tick();
        check("mid_swait_release", s_waitrequest, 1'b0);

        // Read and write together
        drive_cmd(1'b1, 1'b1, 'h500, 1);
        tick();
        set_idle();
        check("rw_as_write", m_write, 1'b1);
        check("rw_no_read", m_read, 1'b0);
        check("rw_proto_err", proto_err, 1'b1);
        drain();

        // Burst count 0 forwarded as 1
        do_reset();
        tick();
        drive_cmd(1'b0, 1'b1, 'h600, 0);
        tick();
        set_idle();
        check("b0_burst_1", m_burstcount, 1);
        check("b0_proto_err", proto_err, 1'b1);
        drain();

        // Randomized traffic
        do_reset();
        tick();
        for (int c = 0; c < 800; c++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 30) drive_cmd(1'b0, 1'b1, $urandom, $urandom_range(1, 4));
            else if (r < 55) drive_cmd(1'b1, 1'b0, $urandom,
                                       ($urandom_range(0, 9) == 0) ? 64 : $urandom_range(1, 8));
            else begin
                s_read  = 1'b0;
                s_write = 1'b0;
            end
            m_waitrequest   = ($urandom_range(0, 3) == 0);
            m_readdatavalid = (pend_m > 0) && ($urandom_range(0, 1) == 1);
            m_readdata      = rand_data();
            tick();
        end
        drain();
        tick();
        check("rand_no_proto_err", proto_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
